packet_serializer: RTL

PACKET_SERIALIZER -- requirements
Module: packet_serializer

---
 rtl/packet_serializer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/packet_serializer.sv
// packet_serializer: accepts a frame of up to MAX_PACKETS words and streams it out
// as AXI-stream beats tagged with the beat index. Define PACKET_SERIALIZER_FRAME_CNT_EN for frame_cnt_o.
module packet_serializer #(
  parameter int  MAX_PACKETS        = 4,
  parameter int  HEADER_WIDTH_BYTES = 1,
  parameter int  DATA_WIDTH_BYTES   = 2,
  localparam int DW                 = DATA_WIDTH_BYTES * 8,
  localparam int HW                 = HEADER_WIDTH_BYTES * 8,
  localparam int LW                 = $clog2(MAX_PACKETS) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [LW-1:0]             length_i,
  input  logic [MAX_PACKETS*DW-1:0] data_i,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      tx_last,
  output logic [HW+DW-1:0]          tx_data
`ifdef PACKET_SERIALIZER_FRAME_CNT_EN
  ,
  output logic [15:0]               frame_cnt_o
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [LW-1:0]             len_q, len_d;
  logic [LW-1:0]             cnt_q, cnt_d;
  logic [MAX_PACKETS*DW-1:0] data_q, data_d;

  logic [LW-1:0]             len_clamped;
  logic [DW-1:0]             word_sel;
  logic                      last_beat;

  // Oversized lengths are clamped so the counter never runs past the stored words.
  always_comb begin
    len_clamped = length_i;
    if (length_i > LW'(MAX_PACKETS)) begin
      len_clamped = LW'(MAX_PACKETS);
    end
  end

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < MAX_PACKETS; i++) begin
      if (cnt_q == LW'(i)) begin
        word_sel = data_q[i*DW +: DW];
      end
    end
  end

  assign last_beat = (cnt_q == (len_q - LW'(1)));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    ready_o  = 1'b0;
    tx_valid = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          len_d  = len_clamped;
          data_d = data_i;
          cnt_d  = '0;
          // Zero-length frames are swallowed without leaving IDLE.
          if (len_clamped != '0) begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          if (last_beat) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + LW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Beat payload is a pure function of held state, so it is stable while stalled.
  assign tx_last = tx_valid && last_beat;
  assign tx_data = tx_valid ? {HW'(cnt_q), word_sel} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

`ifdef PACKET_SERIALIZER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Counts completed frames only; wraps naturally at 16 bits.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (tx_valid && tx_ready && last_beat) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`else
  // No frame counter in this build.
`endif

endmodule
